// File: rtl/moore_patdet_pkg.sv
// Shared defaults and helpers for the multi-pattern Moore sequence detector.
package moore_patdet_pkg;

  localparam int unsigned PAT_LEN_DEF = 32'd4;
  localparam int unsigned NUM_PAT_DEF = 32'd2;
  localparam int unsigned CNT_W_DEF   = 32'd8;

  // Bits needed for a fill counter that counts 0..pat_len inclusive.
  function automatic int unsigned fill_width(input int unsigned pat_len);
    return $clog2(pat_len + 32'd1);
  endfunction

endpackage

// File: rtl/patdet_slot.sv
// One pattern slot: shadow pattern/mask/overlap, saturating fill counter,
// masked compare against the next history value and the registered match.
module patdet_slot
  import moore_patdet_pkg::*;
#(
  parameter int unsigned PAT_LEN = PAT_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load_i,
  input  logic               din_valid_i,
  input  logic [PAT_LEN-1:0] hist_n_i,
  input  logic [PAT_LEN-1:0] cfg_pattern_i,
  input  logic [PAT_LEN-1:0] cfg_mask_i,
  input  logic               cfg_overlap_i,
  output logic               hit_o,
  output logic               match_o
);

  localparam int unsigned      FW       = fill_width(PAT_LEN);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] mask_q;
  logic               ovl_q;
  logic [FW-1:0]      fill_q;
  logic [FW-1:0]      fill_d;
  logic [FW-1:0]      fill_inc_s;
  logic               hit_s;
  logic               match_q;

  // Fill count after accepting this bit, compare result and next fill value.
  always_comb begin
    fill_inc_s = fill_q;
    hit_s      = 1'b0;
    fill_d     = fill_q;
    if (fill_q == FILL_MAX) begin
      fill_inc_s = fill_q;
    end else begin
      fill_inc_s = fill_q + FW'(1);
    end
    if (cfg_load_i) begin
      fill_d = {FW{1'b0}};
    end else if (din_valid_i) begin
      // A full window is required so the zero-filled history never matches.
      hit_s = (fill_inc_s == FILL_MAX) &&
              (((hist_n_i ^ pat_q) & mask_q) == {PAT_LEN{1'b0}});
      if (hit_s && !ovl_q) begin
        fill_d = {FW{1'b0}};
      end else begin
        fill_d = fill_inc_s;
      end
    end else begin
      fill_d = fill_q;
    end
  end

  // Slot state: config shadows on load, fill counter, registered match strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= {PAT_LEN{1'b0}};
      mask_q  <= {PAT_LEN{1'b0}};
      ovl_q   <= 1'b0;
      fill_q  <= {FW{1'b0}};
      match_q <= 1'b0;
    end else begin
      if (cfg_load_i) begin
        pat_q  <= cfg_pattern_i;
        mask_q <= cfg_mask_i;
        ovl_q  <= cfg_overlap_i;
      end
      fill_q  <= fill_d;
      match_q <= hit_s;
    end
  end

  assign hit_o   = hit_s;
  assign match_o = match_q;

endmodule

// File: rtl/moore_multi_pattern_detector.sv
// Multi-pattern Moore serial sequence detector: shared bit history, one
// patdet_slot per pattern, saturating hit counter.
// Optional interrupt output enabled by defining PATDET_IRQ_EN.
module moore_multi_pattern_detector
  import moore_patdet_pkg::*;
#(
  parameter int unsigned PAT_LEN = PAT_LEN_DEF,
  parameter int unsigned NUM_PAT = NUM_PAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       din,
  input  logic                       din_valid,
  input  logic                       cfg_load,
  input  logic [NUM_PAT*PAT_LEN-1:0] cfg_pattern,
  input  logic [NUM_PAT*PAT_LEN-1:0] cfg_mask,
  input  logic [NUM_PAT-1:0]         cfg_overlap,
  input  logic                       count_clr,
  output logic [NUM_PAT-1:0]         match,
`ifdef PATDET_IRQ_EN
  output logic                       irq,
  input  logic                       irq_ack,
`endif
  output logic [CNT_W-1:0]           hit_count
);

  // Only the PAT_LEN-1 most recent bits need storing; the incoming bit
  // completes the window.
  logic [PAT_LEN-2:0] hist_q;
  logic [PAT_LEN-2:0] hist_d;
  logic [PAT_LEN-1:0] hist_n_s;
  logic [NUM_PAT-1:0] hit_s;
  logic               any_hit_s;
  logic [CNT_W-1:0]   hit_count_q;
  logic [CNT_W-1:0]   hit_count_d;

  assign hist_n_s  = {hist_q, din};
  assign any_hit_s = |hit_s;

  // Next history: cleared on load, shifted on valid bits, otherwise held.
  always_comb begin
    hist_d = hist_q;
    if (cfg_load) begin
      hist_d = {(PAT_LEN-1){1'b0}};
    end else if (din_valid) begin
      hist_d = hist_n_s[PAT_LEN-2:0];
    end else begin
      hist_d = hist_q;
    end
  end

  // Next hit count: clear wins, otherwise one step per hitting edge, no wrap.
  always_comb begin
    hit_count_d = hit_count_q;
    if (count_clr) begin
      hit_count_d = {CNT_W{1'b0}};
    end else if (any_hit_s && (hit_count_q != {CNT_W{1'b1}})) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end else begin
      hit_count_d = hit_count_q;
    end
  end

  // Shared history and hit counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q      <= {(PAT_LEN-1){1'b0}};
      hit_count_q <= {CNT_W{1'b0}};
    end else begin
      hist_q      <= hist_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign hit_count = hit_count_q;

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_slot
    patdet_slot #(
      .PAT_LEN(PAT_LEN)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .cfg_load_i   (cfg_load),
      .din_valid_i  (din_valid),
      .hist_n_i     (hist_n_s),
      .cfg_pattern_i(cfg_pattern[k*PAT_LEN +: PAT_LEN]),
      .cfg_mask_i   (cfg_mask[k*PAT_LEN +: PAT_LEN]),
      .cfg_overlap_i(cfg_overlap[k]),
      .hit_o        (hit_s[k]),
      .match_o      (match[k])
    );
  end

`ifdef PATDET_IRQ_EN
  logic irq_q;

  // Sticky interrupt: a new hit outranks an acknowledge in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (any_hit_s) begin
      irq_q <= 1'b1;
    end else if (irq_ack) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_moore_multi_pattern_detector.sv
// Self-checking bench for moore_multi_pattern_detector (default parameters).
module tb_moore_multi_pattern_detector;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [7:0] cfg_mask = 8'h00;
  logic [1:0] cfg_overlap = 2'b00;
  logic       count_clr = 1'b0;
  logic [1:0] match;
  logic [7:0] hit_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: the valid bits received and, per slot, how many
  // bits count toward the next possible match.
  bit         mq[$];
  int         since[2];
  logic [3:0] mpat[2];
  logic [3:0] mmask[2];
  logic       movl[2];
  logic [1:0] exp_match;
  int         exp_cnt;

  moore_multi_pattern_detector dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_mask   (cfg_mask),
    .cfg_overlap(cfg_overlap),
    .count_clr  (count_clr),
    .match      (match),
    .hit_count  (hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 2; k++) begin
      since[k] = 0; mpat[k] = 4'h0; mmask[k] = 4'h0; movl[k] = 1'b0;
    end
    exp_match = 2'b00;
    exp_cnt   = 0;
  endtask

  task automatic model_update(input logic d, input logic v, input logic ld, input logic clr);
    bit any;
    any = 1'b0;
    if (ld) begin
      for (int k = 0; k < 2; k++) begin
        mpat[k] = cfg_pattern[k*4 +: 4]; mmask[k] = cfg_mask[k*4 +: 4];
        movl[k] = cfg_overlap[k]; since[k] = 0;
      end
      mq.delete();
      exp_match = 2'b00;
    end else if (v) begin
      mq.push_back(d);
      if (mq.size() > L) void'(mq.pop_front());
      for (int k = 0; k < 2; k++) begin
        int  s;
        bit  h;
        s = since[k] + 1;
        h = 1'b0;
        if (s >= L) begin
          h = 1'b1;
          // Bit j of the pattern is the bit received j valid cycles ago.
          for (int j = 0; j < L; j++)
            if (mmask[k][j] && (mq[mq.size()-1-j] != mpat[k][j])) h = 1'b0;
        end
        exp_match[k] = h;
        if (h) any = 1'b1;
        since[k] = (h && !movl[k]) ? 0 : ((s > L) ? L : s);
      end
    end else begin
      exp_match = 2'b00;
    end
    if (clr) exp_cnt = 0;
    else if (any && exp_cnt < 255) exp_cnt++;
  endtask

  // One clock: drive, update model, sample #1 after the edge, compare.
  task automatic step(input logic d, input logic v, input logic ld, input logic clr);
    din = d; din_valid = v; cfg_load = ld; count_clr = clr;
    model_update(d, v, ld, clr);
    @(posedge clk);
    #1;
    check("match", 32'(match), 32'(exp_match));
    check("hit_count", 32'(hit_count), 32'(exp_cnt));
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [7:0] m, input logic [1:0] o);
    cfg_pattern = p; cfg_mask = m; cfg_overlap = o;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Send n valid bits MSB first; record per-slot pulse vectors by bit index.
  task automatic send_bits(input logic [31:0] bits, input int n,
                           output logic [31:0] p0, output logic [31:0] p1);
    p0 = 32'h0; p1 = 32'h0;
    for (int i = 0; i < n; i++) begin
      step(bits[n-1-i], 1'b1, 1'b0, 1'b0);
      p0[i] = match[0];
      p1[i] = match[1];
    end
  endtask

  initial begin
    logic [31:0] p0;
    logic [31:0] p1;
    logic [1:0]  gtab[8];
    int          npulse;

    model_reset();
    #3;
    check("reset_match", 32'(match), 32'h0);
    check("reset_count", 32'(hit_count), 32'h0);
    #5 reset = 1'b0;

    // Overlap: slot0 1001, slot1 1101.
    load_cfg(8'b1101_1001, 8'hFF, 2'b11);
    send_bits(32'b01001101101, 11, p0, p1);
    check("ovl_pulses0", p0, 32'h010);
    check("ovl_pulses1", p1, 32'h480);
    check("ovl_count", 32'(hit_count), 32'd3);

    // Slot 1 non-overlapping.
    load_cfg(8'b1101_1001, 8'hFF, 2'b01);
    send_bits(32'b01001101101, 11, p0, p1);
    check("novl_pulses1", p1, 32'h080);
    check("novl_count", 32'(hit_count), 32'd2);

    // Don't-care bit in slot 0: 1x01.
    load_cfg(8'b0000_1001, 8'b1111_1011, 2'b11);
    send_bits(32'b1101001, 7, p0, p1);
    check("dc_pulses0", p0, 32'h048);
    check("dc_count", 32'(hit_count), 32'd2);

    // Gaps inside 1001: entries are {valid, din}.
    load_cfg(8'b0000_1001, 8'hFF, 2'b11);
    gtab = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11};
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      step(gtab[i][0], gtab[i][1], 1'b0, 1'b0);
      if (match[0]) npulse++;
    end
    check("gap_last", 32'(match[0]), 32'h1);
    check("gap_npulse", 32'(npulse), 32'd1);

    // Reload after 100 restarts the window.
    load_cfg(8'b0000_1001, 8'hFF, 2'b11);
    send_bits(32'b100, 3, p0, p1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(32'b1, 1, p0, p1);
    check("reload_nomatch", p0, 32'h0);

    // Saturation: mask all-zero matches every bit once filled.
    load_cfg(8'h00, 8'h00, 2'b11);
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    check("sat_count", 32'(hit_count), 32'd255);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_vs_hit_count", 32'(hit_count), 32'd0);
    check("clr_vs_hit_match", 32'(match), 32'h3);

    // Asynchronous reset mid-pattern.
    load_cfg(8'b0000_1001, 8'hFF, 2'b11);
    send_bits(32'b1000, 4, p0, p1);
    check("pre_reset_match", 32'(match[0]), 32'h0);
    send_bits(32'b1, 1, p0, p1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_match", 32'(match), 32'h0);
    check("async_count", 32'(hit_count), 32'h0);
    #1 reset = 1'b0;
    send_bits(32'b111, 3, p0, p1);
    check("post_reset_nomatch", p0 | p1, 32'h0);

    // Randomized traffic with occasional reconfiguration and clears.
    for (int i = 0; i < 600; i++) begin
      logic ld;
      ld = ($urandom_range(0, 39) == 0);
      if (ld) begin
        cfg_pattern = 8'($urandom());
        cfg_mask    = 8'($urandom()) & 8'($urandom() | 32'h0000_0077);
        cfg_overlap = 2'($urandom());
      end
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), ld,
           ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/moore_multi_pattern_detector.md
Name: moore_multi_pattern_detector

Overview:
- Generalised Moore-style serial sequence detector.
- Compares a 1-bit input stream against NUM_PAT runtime-programmable patterns of PAT_LEN bits each; every pattern has its own don't-care mask.
- Overlap / non-overlap mode is selected per pattern.
- Sits behind serial front-ends; drives registered per-pattern match strobes and a saturating hit counter to control logic.

Parameters:
- PAT_LEN, 4, bits per pattern (>=2).
- NUM_PAT, 2, number of independent pattern slots (>=1).
- CNT_W, 8, width of the hit counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only when high.
- cfg_load  in  1  latch cfg_pattern / cfg_mask / cfg_overlap into shadow registers.
- cfg_pattern  in  NUM_PAT*PAT_LEN  slot k occupies [k*PAT_LEN +: PAT_LEN]; MSB is the oldest bit.
- cfg_mask  in  NUM_PAT*PAT_LEN  1 = bit compared, 0 = don't care.
- cfg_overlap  in  NUM_PAT  1 = overlapping detection for that slot.
- count_clr  in  1  synchronous clear of hit_count.
- match  out  NUM_PAT  registered Moore output per slot.
- hit_count  out  CNT_W  saturating count of cycles with any match.

Behaviour:
- Reset (async): history=0; all fill counters=0; pattern/mask/overlap shadows=0; match=0; hit_count=0.
- State:
  - shared shift register hist[PAT_LEN-1:0];
  - per-slot fill[k], range 0..PAT_LEN, saturating.
- Per edge with din_valid=1 and cfg_load=0:
  - hist_n = {hist[PAT_LEN-2:0], din}.
  - fill_n[k] = min(fill[k]+1, PAT_LEN).
  - hit[k] = (fill_n[k]==PAT_LEN) && (((hist_n ^ pat[k]) & mask[k]) == 0).
  - match[k] <= hit[k].
  - If hit[k] and overlap[k]=0, then fill[k] <= 0 (matched bits consumed). Otherwise fill[k] <= fill_n[k].
- Edge with din_valid=0: hist and fill hold; match <= 0. Each match pulse lasts exactly one cycle per qualifying bit.
- Latency: match[k] rises on the same clk edge that samples the final pattern bit. It is a Moore output: visible for the cycle following that edge and driven from a register only, with no combinational path from din.
- cfg_load=1:
  - shadows <= cfg inputs;
  - hist <= 0; all fill <= 0; match <= 0;
  - din is ignored that cycle.
  - cfg_load has priority over din_valid.
- No match is possible until PAT_LEN valid bits have been received since reset or cfg_load. This suppresses false hits on the zero-filled history.
- Mask all-zero: slot matches on every valid bit once filled. In non-overlap mode this gives one hit every PAT_LEN valid bits.
- Several slots may hit on the same edge; each match bit asserts independently.
- hit_count:
  - +1 on each edge where any hit[k]=1 (increment is 1 regardless of how many slots hit);
  - saturates at all-ones, with no wrap;
  - count_clr has priority over an increment in the same cycle (result 0).
  - cfg_load does not clear hit_count.
- Reset asserted mid-stream: all state is cleared immediately (asynchronously), including partial matches.

Optional Feature:
- Macro: PATDET_IRQ_EN.
- When defined, add ports irq (out, 1) and irq_ack (in, 1).
  - irq sets on the edge after any hit and stays high until irq_ack.
  - irq_ack and a new hit in the same cycle: irq stays 1.
  - irq reset value is 0.
- When undefined, neither port exists and there is no extra logic.

Decomposition:
- Package moore_patdet_pkg holds:
  - default PAT_LEN / NUM_PAT / CNT_W localparams;
  - a fill-counter width function, clog2(PAT_LEN+1).
- One natural sub-module, patdet_slot: holds one slot's shadow config, fill counter, compare and match register. It takes hist_n, din_valid and cfg_load as inputs.
- Top level owns the shared shift register, the generate loop over slots, hit_count and the optional irq.

Test Plan:
- Overlap, slots {1001, 1101}, masks 1111, both overlap=1; stream 0,1,0,0,1,1,0,1,1,0,1 with din_valid=1 -> match[0] pulses after bit 4; match[1] pulses after bits 7 and 10; hit_count=3.
- Same stream with slot 1 overlap=0 -> match[1] pulses after bit 7 only; hit_count=2.
- Don't-care: slot 0 = 1x01 (pattern 1001, mask 1011); stream 1,1,0,1,0,0,1 -> match[0] after bit 3 and after bit 6.
- Gaps: insert din_valid=0 cycles inside a 1001 sequence -> a single match pulse on the edge of the final valid bit; match stays 0 during the gaps.
- cfg_load after 3 bits of 100, then send 1 -> no match, because fill restarts. Count saturation with CNT_W=2: 5 hits -> hit_count=3. count_clr together with a hit -> hit_count=0.
- Assert reset mid-pattern asynchronously -> match=0 and hit_count=0 immediately; the next 3 bits cannot produce a match. If PATDET_IRQ_EN is defined: irq holds after a hit until irq_ack.
